// File: rtl/partition_error_meter_pkg.sv
// Shared types and width helpers for the partition error meter.
// The MAE datapath is built only when PARTITION_MAE_EN is defined.
package partition_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Enough bits for N_OUT mismatching bits on every one of 2^N_IN vectors.
  function automatic int HAM_W(input int n_in, input int n_out);
    return n_in + $clog2(n_out + 1);
  endfunction

endpackage

// File: rtl/partition_error_meter_if.sv
// Bundle between the meter and the exact/approximate partition pair.
// The meter drives the sweep vector and results; the environment drives start and the partition outputs.
interface partition_error_meter_if
  import partition_meter_pkg::*;
#(
  parameter int N_IN  = 7,
  parameter int N_OUT = 4
) ();

  logic                          start;
  logic [N_IN-1:0]               pi_out;
  logic [N_OUT-1:0]              po_exact;
  logic [N_OUT-1:0]              po_approx;
  logic                          busy;
  logic                          done;
  logic [N_IN:0]                 err_count;
  logic [HAM_W(N_IN, N_OUT)-1:0] ham_sum;
  logic [N_OUT-1:0]              max_abs_err;

  modport master (
    input  start, po_exact, po_approx,
    output pi_out, busy, done, err_count, ham_sum, max_abs_err
  );

  modport slave (
    output start, po_exact, po_approx,
    input  pi_out, busy, done, err_count, ham_sum, max_abs_err
  );

endinterface

// File: rtl/partition_error_meter_popcount.sv
// Combinational population count of a W-bit vector.
module partition_popcount #(
  parameter int W = 4
) (
  input  logic [W-1:0]             vec,
  output logic [$clog2(W+1)-1:0]   count
);

  localparam int CW = $clog2(W + 1);

  // Sum every bit of the vector.
  always_comb begin
    count = {CW{1'b0}};
    for (int i = 0; i < W; i++) begin
      count = count + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/partition_error_meter.sv
// Exhaustive error meter: sweeps every input vector through both partitions and accumulates
// mismatch count, Hamming distance and (with PARTITION_MAE_EN) the maximum absolute error.
module partition_error_meter
  import partition_meter_pkg::*;
#(
  parameter int N_IN  = 7,
  parameter int N_OUT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  partition_error_meter_if.master  bus
);

  localparam int HW = HAM_W(N_IN, N_OUT);
  localparam int CW = $clog2(N_OUT + 1);
  localparam int EW = N_IN + 1;

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_SWEEP = SWEEP;
  localparam logic [1:0] S_DRAIN = DRAIN;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0]       state_q, state_d;
  logic [N_IN-1:0]  pi_q, pi_d;
  logic             s1_valid_q, s1_valid_d;
  logic [N_OUT-1:0] s1_exact_q, s1_exact_d;
  logic [N_OUT-1:0] s1_approx_q, s1_approx_d;
  logic [EW-1:0]    err_q, err_d;
  logic [HW-1:0]    ham_q, ham_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CW-1:0]    pop_s;
  logic             start_acc_s;

  // start is only honoured while no sweep is in flight.
  assign start_acc_s = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));

  partition_popcount #(.W(N_OUT)) u_popcount (
    .vec   (s1_exact_q ^ s1_approx_q),
    .count (pop_s)
  );

  // FSM, vector counter, S1 capture and S2 accumulation.
  always_comb begin
    state_d     = state_q;
    pi_d        = pi_q;
    s1_valid_d  = (state_q == S_SWEEP);
    s1_exact_d  = bus.po_exact;
    s1_approx_d = bus.po_approx;
    err_d       = err_q;
    ham_d       = ham_q;

    if (s1_valid_q) begin
      err_d = err_q + EW'(s1_exact_q != s1_approx_q);
      ham_d = ham_q + HW'(pop_s);
    end else begin
      err_d = err_q;
      ham_d = ham_q;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_acc_s) begin
          state_d = S_SWEEP;
          pi_d    = {N_IN{1'b0}};
          err_d   = {EW{1'b0}};
          ham_d   = {HW{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      S_SWEEP: begin
        // Hold all-ones so the counter never wraps back to vector 0.
        if (pi_q == {N_IN{1'b1}}) begin
          state_d = S_DRAIN;
        end else begin
          pi_d = pi_q + N_IN'(1);
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_SWEEP) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // State and pipeline registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pi_q        <= {N_IN{1'b0}};
      s1_valid_q  <= 1'b0;
      s1_exact_q  <= {N_OUT{1'b0}};
      s1_approx_q <= {N_OUT{1'b0}};
      err_q       <= {EW{1'b0}};
      ham_q       <= {HW{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pi_q        <= pi_d;
      s1_valid_q  <= s1_valid_d;
      s1_exact_q  <= s1_exact_d;
      s1_approx_q <= s1_approx_d;
      err_q       <= err_d;
      ham_q       <= ham_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef PARTITION_MAE_EN
  logic [N_OUT:0]   sub_s;
  logic [N_OUT-1:0] abs_s;
  logic [N_OUT-1:0] mae_q, mae_d;

  // Unsigned |exact - approx| via an N_OUT+1-bit subtract, then running max.
  always_comb begin
    sub_s = {1'b0, s1_exact_q} - {1'b0, s1_approx_q};
    if (sub_s[N_OUT]) begin
      abs_s = {N_OUT{1'b0}} - sub_s[N_OUT-1:0];
    end else begin
      abs_s = sub_s[N_OUT-1:0];
    end
    if (start_acc_s) begin
      mae_d = {N_OUT{1'b0}};
    end else if (s1_valid_q && (abs_s > mae_q)) begin
      mae_d = abs_s;
    end else begin
      mae_d = mae_q;
    end
  end

  // Running maximum register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mae_q <= {N_OUT{1'b0}};
    end else begin
      mae_q <= mae_d;
    end
  end

  assign bus.max_abs_err = mae_q;
`else
  assign bus.max_abs_err = {N_OUT{1'b0}};
`endif

  assign bus.pi_out    = pi_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err_count = err_q;
  assign bus.ham_sum   = ham_q;

endmodule

// File: tb/tb_partition_error_meter.sv
// Directed bench for partition_error_meter (N_IN=7, N_OUT=4) with combinational partition models.
module tb_partition_error_meter;

`ifdef PARTITION_MAE_EN
  localparam bit MAE = 1'b1;
`else
  localparam bit MAE = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   mode;
  int   checks;
  int   failures;
  logic [3:0] sum_s;

  partition_error_meter_if #(.N_IN(7), .N_OUT(4)) bus ();

  partition_error_meter #(.N_IN(7), .N_OUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Partition pair models.
  always_comb begin
    sum_s = bus.pi_out[3:0] + {1'b0, bus.pi_out[6:4]};
    case (mode)
      0: begin bus.po_exact = sum_s;             bus.po_approx = sum_s; end
      1: begin bus.po_exact = bus.pi_out[3:0];   bus.po_approx = 4'b0000; end
      2: begin bus.po_exact = sum_s;             bus.po_approx = sum_s ^ 4'b0001; end
      3: begin bus.po_exact = bus.pi_out[3:0];   bus.po_approx = bus.pi_out[3:0] | 4'b1000; end
      default: begin bus.po_exact = 4'b0000;     bus.po_approx = 4'b0000; end
    endcase
  end

  task automatic run_sweep(input bit pulse, output int cycles, output int pi_bad,
                           output int err0, output int ham0);
    int exp_pi;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cycles = 0;
    pi_bad = 0;
    err0 = int'(bus.err_count);
    ham0 = int'(bus.ham_sum);
    if (bus.pi_out !== 7'd0 || bus.busy !== 1'b1 || bus.done !== 1'b0) pi_bad++;
    while (cycles < 300) begin
      @(posedge clk);
      #1;
      cycles++;
      if (pulse && cycles < 120) bus.start = cycles[0];
      else bus.start = 1'b0;
      exp_pi = (cycles < 128) ? cycles : 127;
      if (bus.pi_out !== exp_pi[6:0]) pi_bad++;
      if (bus.done === 1'b1) break;
      if (bus.busy !== 1'b1) pi_bad++;
    end
    bus.start = 1'b0;
  endtask

  task automatic check_results(input string name, input int cycles, input int pi_bad,
                               input int exp_err, input int exp_ham, input int exp_mae);
    checks++;
    if (cycles !== 129) begin
      failures++;
      $display("FAIL %s latency: got %0d expected 129", name, cycles);
    end
    checks++;
    if (pi_bad !== 0) begin
      failures++;
      $display("FAIL %s sequence: %0d bad pi_out/busy samples expected 0", name, pi_bad);
    end
    checks++;
    if (bus.err_count !== exp_err[7:0]) begin
      failures++;
      $display("FAIL %s err_count: got %0d expected %0d", name, bus.err_count, exp_err);
    end
    checks++;
    if (bus.ham_sum !== exp_ham[9:0]) begin
      failures++;
      $display("FAIL %s ham_sum: got %0d expected %0d", name, bus.ham_sum, exp_ham);
    end
    checks++;
    if (bus.max_abs_err !== exp_mae[3:0]) begin
      failures++;
      $display("FAIL %s max_abs_err: got %0d expected %0d", name, bus.max_abs_err, exp_mae);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin
      failures++;
      $display("FAIL %s flags: got busy=%b done=%b expected busy=0 done=1", name, bus.busy, bus.done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    mode = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.pi_out !== 7'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.err_count !== 8'd0 || bus.ham_sum !== 10'd0 || bus.max_abs_err !== 4'd0) begin
      failures++;
      $display("FAIL reset: got pi=%0d busy=%b done=%b err=%0d ham=%0d mae=%0d expected all 0",
               bus.pi_out, bus.busy, bus.done, bus.err_count, bus.ham_sum, bus.max_abs_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_exact_match();
    int c, pb, e0, h0;
    mode = 0;
    run_sweep(1'b0, c, pb, e0, h0);
    check_results("exact_match", c, pb, 0, 0, 0);
  endtask

  task automatic test_stuck_zero();
    int c, pb, e0, h0;
    mode = 1;
    run_sweep(1'b0, c, pb, e0, h0);
    check_results("stuck_zero", c, pb, 120, 256, MAE ? 15 : 0);
  endtask

  task automatic test_single_bit();
    int c, pb, e0, h0;
    logic [7:0] err_snap;
    logic [9:0] ham_snap;
    mode = 2;
    run_sweep(1'b0, c, pb, e0, h0);
    check_results("single_bit", c, pb, 128, 128, MAE ? 1 : 0);
    err_snap = bus.err_count;
    ham_snap = bus.ham_sum;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b1 || bus.err_count !== err_snap || bus.ham_sum !== ham_snap) begin
      failures++;
      $display("FAIL hold_done: got done=%b err=%0d ham=%0d expected done=1 err=%0d ham=%0d",
               bus.done, bus.err_count, bus.ham_sum, err_snap, ham_snap);
    end
  endtask

  task automatic test_start_ignored();
    int c, pb, e0, h0;
    mode = 2;
    run_sweep(1'b1, c, pb, e0, h0);
    check_results("start_ignored", c, pb, 128, 128, MAE ? 1 : 0);
  endtask

  task automatic test_reset_mid_sweep();
    int c, pb, e0, h0;
    mode = 1;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.pi_out !== 7'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.err_count !== 8'd0 || bus.ham_sum !== 10'd0 || bus.max_abs_err !== 4'd0) begin
      failures++;
      $display("FAIL mid_reset: got pi=%0d busy=%b done=%b err=%0d ham=%0d mae=%0d expected all 0",
               bus.pi_out, bus.busy, bus.done, bus.err_count, bus.ham_sum, bus.max_abs_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mode = 2;
    run_sweep(1'b0, c, pb, e0, h0);
    check_results("after_reset", c, pb, 128, 128, MAE ? 1 : 0);
  endtask

  task automatic test_restart_from_done();
    int c, pb, e0, h0;
    mode = 3;
    run_sweep(1'b0, c, pb, e0, h0);
    checks++;
    if (e0 !== 0 || h0 !== 0) begin
      failures++;
      $display("FAIL restart_clear: got err=%0d ham=%0d at start edge expected 0 0", e0, h0);
    end
    check_results("restart", c, pb, 64, 64, MAE ? 8 : 0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    bus.start = 1'b0;
    rst_n = 1'b0;
    mode = 0;
    test_reset();
    test_exact_match();
    test_stuck_zero();
    test_single_bit();
    test_start_ignored();
    test_reset_mid_sweep();
    test_restart_from_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
